// File: rtl/keypad_ctrl_if.sv
// Bundles the keypad controller's raw scanner inputs, event handshake
// and status flags.
//
// Event handshake: ev_valid is held high while an event is pending, and
// ev_code/ev_repeat stay stable until the consumer takes the event. The
// event transfers on the rising clk edge where ev_valid & ev_ready are
// both 1. ev_ready may be driven independently of ev_valid.
interface keypad_ctrl_if;
  logic       kp_pressed;
  logic [3:0] kp_code;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_repeat;
  logic       ev_ready;
  logic       key_held;
  logic [3:0] held_code;
  logic       ev_overflow;
  logic       ovf_clr;

  // Controller side
  modport master (
    input  kp_pressed, kp_code, ev_ready, ovf_clr,
    output ev_valid, ev_code, ev_repeat, key_held, held_code, ev_overflow
  );

  // Scanner / consumer side
  modport slave (
    output kp_pressed, kp_code, ev_ready, ovf_clr,
    input  ev_valid, ev_code, ev_repeat, key_held, held_code, ev_overflow
  );
endinterface

// File: rtl/keypad_ctrl.sv
// Keypad sequencing controller: debounces raw scanner samples into press
// events, generates auto-repeat events while a key is held, and queues
// events in a 1-deep register with a sticky overflow flag.
module keypad_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned RELEASE_CYC  = 16,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_ctrl_if.master bus,
  output logic [1:0]    dbg_state_o
);

  // With repeat disabled the counter is kept 1 bit wide and never fires.
  localparam int unsigned RPT_TOP    = (REPEAT_DELAY == 0) ? 1 : REPEAT_DELAY;
  localparam int unsigned RPT_RELOAD = (REPEAT_RATE >= RPT_TOP) ? 0 : RPT_TOP - REPEAT_RATE;
  localparam int unsigned AGE_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned GAP_W      = $clog2(RELEASE_CYC + 1);
  localparam int unsigned RPT_W      = $clog2(RPT_TOP + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DEBOUNCE_CYC);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RELEASE_CYC);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(RPT_TOP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       held_code_q, held_code_d;
  logic             ev_valid_q, ev_valid_d;
  logic [3:0]       ev_code_q, ev_code_d;
  logic             ev_repeat_q, ev_repeat_d;
  logic             ovf_q, ovf_d;

  logic             restart, gap_hit, fire, rpt_hit;
  logic             gen_ev, gen_rpt;
  logic [3:0]       cand_nx, gen_code;
  logic [AGE_W-1:0] age_nx;
  logic [GAP_W-1:0] gap_nx;
  logic [RPT_W-1:0] rpt_nx;

  // A new candidate starts on the first press from IDLE or on any code change.
  assign restart = bus.kp_pressed && (state_q == S_IDLE || bus.kp_code != cand_q);
  assign cand_nx = restart ? bus.kp_code : cand_q;
  assign age_nx  = restart ? AGE_W'(1) : ((age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1));
  assign gap_nx  = bus.kp_pressed ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1));
  assign rpt_nx  = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + RPT_W'(1);

  // Release outranks a debounce completion landing on the same edge.
  assign gap_hit = (state_q != S_IDLE) && !bus.kp_pressed && (gap_nx == GAP_MAX);
  assign fire    = ((state_q == S_IDLE && bus.kp_pressed) || state_q == S_PRESS ||
                    (state_q == S_HELD && restart)) && !gap_hit && (age_nx == AGE_MAX);
  assign rpt_hit = (REPEAT_DELAY != 0) && (state_q == S_HELD) && !restart && !gap_hit &&
                   (rpt_nx == RPT_MAX);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      age_q       <= '0;
      gap_q       <= '0;
      rpt_q       <= '0;
      key_held_q  <= 1'b0;
      held_code_q <= '0;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= '0;
      ev_repeat_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      age_q       <= age_d;
      gap_q       <= gap_d;
      rpt_q       <= rpt_d;
      key_held_q  <= key_held_d;
      held_code_q <= held_code_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
      ev_repeat_q <= ev_repeat_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    if (gap_hit)      state_d = S_IDLE;
    else if (fire)    state_d = S_HELD;
    else if (restart) state_d = S_PRESS;
  end

  // Counters, held-key status and the 1-deep event register.
  always_comb begin
    cand_d      = cand_nx;
    age_d       = (state_d == S_IDLE) ? '0 : age_nx;
    gap_d       = (state_d == S_IDLE) ? '0 : gap_nx;
    rpt_d       = '0;
    if (rpt_hit)                                rpt_d = RPT_W'(RPT_RELOAD);
    else if (state_d == S_HELD && !fire)        rpt_d = rpt_nx;
    key_held_d  = (state_d == S_HELD);
    held_code_d = fire ? cand_nx : held_code_q;

    gen_ev      = fire || rpt_hit;
    gen_code    = fire ? cand_nx : held_code_q;
    gen_rpt     = !fire;

    ev_valid_d  = ev_valid_q;
    ev_code_d   = ev_code_q;
    ev_repeat_d = ev_repeat_q;
    ovf_d       = bus.ovf_clr ? 1'b0 : ovf_q;
    if (gen_ev) begin
      if (!ev_valid_q || bus.ev_ready) begin
        ev_valid_d  = 1'b1;
        ev_code_d   = gen_code;
        ev_repeat_d = gen_rpt;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ev_valid_q && bus.ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  assign bus.ev_valid    = ev_valid_q;
  assign bus.ev_code     = ev_code_q;
  assign bus.ev_repeat   = ev_repeat_q;
  assign bus.key_held    = key_held_q;
  assign bus.held_code   = held_code_q;
  assign bus.ev_overflow = ovf_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/keypad_ctrl.md
# keypad_ctrl

Sequencing controller behind the 4x4 keypad scanner. It turns the scanner's raw per-cycle `keypressed`/`keycode` samples into clean, debounced key events with a ready/valid handshake and optional auto-repeat. The raw flag is asserted only on the scan phase that hits the pressed row, so it is 1 for at most one cycle in four while a key is held. Sits between the keypad scanner and the game logic (paddle/menu control).

## Interface
- `DEBOUNCE_CYC`, default 16: cycles a candidate code must persist, without conflict or release, before a press event fires; must be ≥1.
- `RELEASE_CYC`, default 16: consecutive cycles with `kp_pressed`=0 that count as a release; must be ≥5, longer than one scan period.
- `REPEAT_DELAY`, default 50_000_000: cycles from the press event to the first repeat event; 0 disables auto-repeat.
- `REPEAT_RATE`, default 10_000_000: cycles between later repeat events; must be ≥1.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `kp_pressed`  in  1  raw pressed flag from the scanner.
- `kp_code`  in  4  raw keycode from the scanner.
- `ev_valid`  out  1  key event pending.
- `ev_code`  out  4  code of the pending event.
- `ev_repeat`  out  1  0 = initial press, 1 = auto-repeat.
- `ev_ready`  in  1  consumer accepts the event when `ev_valid`&`ev_ready`.
- `key_held`  out  1  a debounced key is currently down.
- `held_code`  out  4  code of the held key; valid while `key_held`=1.
- `ev_overflow`  out  1  sticky flag: an event was dropped.
- `ovf_clr`  in  1  clears `ev_overflow`.

## Operation
- **Reset.** While `rst_n`=0 at a clock edge:
  - state = IDLE; all counters = 0.
  - `ev_valid`, `ev_code`, `ev_repeat`, `key_held`, `held_code`, `ev_overflow` all = 0.
  - Reset applied mid-operation aborts any debounce or hold and drops a pending event, with no release or overflow side effects.
- **Registers.** `cand` (4b); `age` (debounce counter); `gap` (release counter); `rpt` (repeat counter). Each counter is `$clog2(max+1)` bits wide and saturates; none wraps.
- **Gap counter (all non-IDLE states).** A sample with `kp_pressed`=1 and `kp_code`==`cand` clears `gap`. A sample with `kp_pressed`=0 increments `gap`.
- **IDLE**
  - On `kp_pressed`=1: `cand`←`kp_code`, `age`←1, `gap`←0, go to PRESS.
- **PRESS**
  - `age` increments every cycle.
  - `kp_pressed`=1 with a different code: `cand`←new code, `age`←1.
  - `gap` reaching `RELEASE_CYC`: go to IDLE, no event.
  - `age` reaching `DEBOUNCE_CYC`: go to HELD; generate a press event (`cand`, repeat=0); set `key_held`=1, `held_code`=`cand`; `rpt`←0.
- **HELD**
  - `rpt` increments each cycle.
  - If `REPEAT_DELAY`≠0: generate a repeat event when `rpt` hits `REPEAT_DELAY`, then every `REPEAT_RATE` cycles after that (`rpt` reloads to `REPEAT_DELAY-REPEAT_RATE`).
  - `kp_pressed`=1 with a different code: `key_held`←0; `cand`←new code, `age`←1, `gap`←0; go to PRESS.
  - `gap` reaching `RELEASE_CYC`: `key_held`←0, go to IDLE. No release event is emitted.
- **Event register (1-deep)**
  - Generated event while `ev_valid`=0, or while `ev_valid`&`ev_ready`: load `ev_code`/`ev_repeat` and set `ev_valid`=1. Back-to-back events are allowed; `ev_valid` stays high.
  - Generated event while `ev_valid`=1 and `ev_ready`=0: the new event is dropped, the held event is unchanged, and `ev_overflow`←1.
  - Handshake with no new event: `ev_valid`←0.
  - `ev_code`/`ev_repeat` are stable while `ev_valid`=1 and `ev_ready`=0.
  - `ovf_clr` and an overflow in the same cycle: overflow wins (flag stays 1).

## Timing
- All outputs are registered; there are no combinational input→output paths.
- **Press.** Capture edge E0 (IDLE sampling `kp_pressed`=1). `ev_valid` and `key_held` rise after edge E0+`DEBOUNCE_CYC`-1, provided there is no conflicting code and no release in between.
- **Release.** `key_held` falls `RELEASE_CYC` cycles after the last matching `kp_pressed`=1 sample.
- **Repeat.** The first repeat event registers `REPEAT_DELAY` cycles after the press event; later ones follow at `REPEAT_RATE` spacing.
- **Handshake.** Acceptance happens on the edge where `ev_valid`&`ev_ready`=1. `ev_valid` drops on the next cycle unless a new event loads in the same edge.
- **Scan cadence.** A normally held key produces a pattern of 1 cycle high, 3 cycles low on `kp_pressed`. Since `gap` never exceeds 3 under that pattern, `RELEASE_CYC`≥5 guarantees no false release.

## Test plan
Bench parameters for all scenarios: `DEBOUNCE_CYC`=8, `RELEASE_CYC`=6, `REPEAT_DELAY`=20, `REPEAT_RATE`=10.

1. **Reset.** Hold `rst_n`=0 for 3 cycles with `kp_pressed` toggling. Required: all outputs 0, and no event for 8 cycles after release of reset with `kp_pressed`=0.
2. **Debounced press.** Drive key 5 at the 1-in-4 cadence with `ev_ready`=1. Required: exactly one event {code 5, repeat 0} 8 cycles after the first sample; `key_held`=1, `held_code`=5; then stop and `key_held`=0 six cycles after the last sample.
3. **Glitch and code change.** One sample of key 3, then silence. Required: no event, state returns to IDLE. Next, key 3 followed by key 7 after 4 cycles. Required: a single event with code 7, 8 cycles after the first 7 sample.
4. **Auto-repeat.** Hold key 2 for 60 cycles after the press event with `ev_ready`=1. Required: repeat events (`ev_repeat`=1, code 2) at +20, +30, +40 and +50 cycles, and none after release.
5. **Backpressure and overflow.** Hold `ev_ready`=0 with repeat active. Required: `ev_valid`=1 with the first event unchanged, and `ev_overflow`=1 at the +20 repeat. Then pulse `ovf_clr`. Required: flag clears. Then a 1-cycle `ev_ready` coinciding with a repeat. Required: the new event loads and `ev_valid` stays high.
6. **Reset mid-hold.** Assert `rst_n`=0 while `key_held`=1 and an event is pending. Required: next cycle all outputs 0 and no overflow. With the key still held after reset, a fresh press event appears after 8 cycles.
